// File: rtl/fa_bist_checker.sv
// Purpose: BIST sequencer/checker that walks all 8 {a,b,cin} vectors through an attached full adder and grades the response.
// Latency: done pulses 8*(SETTLE+1)+1 cycles after start is accepted; each vector is held SETTLE+1 cycles.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while a test runs.
module fa_bist_checker #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic             dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       idx;
  logic [3:0]       settle;
  logic [2:0]       vec_q;
  logic             cmp_edge;
  logic             last_vec;
  logic             mismatch;
  logic [1:0]       golden;
  logic [ERR_W-1:0] err_nxt;

  // Golden response and compare qualification; idx always equals the vector on dut_* while in DRIVE
  always_comb begin
    golden   = {1'b0, idx[2]} + {1'b0, idx[1]} + {1'b0, idx[0]};
    cmp_edge = (state == DRIVE) && (settle == SETTLE_C);
    last_vec = (idx == 3'd7);
    mismatch = cmp_edge && ({dut_cout, dut_sum} != golden);
    err_nxt  = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1) : err_count;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept start in IDLE, leave DRIVE after the last vector's compare, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (cmp_edge && last_vec) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; stimulus comes straight from its own register
  always_comb begin
    busy                     = (state == DRIVE);
    done                     = (state == DONE);
    {dut_a, dut_b, dut_cin}  = vec_q;
  end

  // Vector sequencing, settle timing and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx              <= 3'd0;
      settle           <= 4'd0;
      vec_q            <= 3'd0;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vec_q <= 3'd0;
          if (start) begin
            idx              <= 3'd0;
            settle           <= 4'd0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (cmp_edge) begin
            err_count <= err_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= idx;
              first_fail_valid <= 1'b1;
            end
            settle <= 4'd0;
            idx    <= idx + 3'd1;
            // Final compare: grade with the count that includes this vector
            if (last_vec) begin
              vec_q <= 3'd0;
              pass  <= (err_nxt == '0);
            end else begin
              vec_q <= idx + 3'd1;
            end
          end else begin
            settle <= settle + 4'd1;
          end
        end
        default: begin
          vec_q <= 3'd0;
        end
      endcase
    end
  end

endmodule
